or16_deser: RTL and testbench

Bit-serial receiver for the 16-bit bitwise OR datapath. It accepts operand bit pairs (a_i, b_i) one per cycle, LSB first, over a valid/ready stream, and computes a_i | b_i per bit. It assembles the results into a parallel word and presents it on a valid/ready output. It sits between a serial link or narrow bus and any consumer that expects an Or16-style parallel result.

---
 rtl/or16_deser.sv | 153 +++++++++++++++
 tb/tb_or16_deser.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/or16_deser.sv
// or16_deser - bit-serial receiver for the bitwise OR datapath.
//
// Accepts operand bit pairs (in_a, in_b) LSB first, one per accepted cycle,
// stores in_a | in_b at the current bit position and presents the assembled
// WIDTH-bit word on a valid/ready output.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   serial bit pair present
//   in_ready   bit pair accepted this cycle (!out_valid || out_ready)
//   in_first   marks bit 0 of a new word, qualified by in_valid
//   in_a/in_b  operand bits for the current position
//   out_valid  result word held on out
//   out_ready  consumer takes the word this cycle
//   out        assembled result, out[i] = a_i | b_i
//   err        one-cycle framing-error pulse (only with OR16_DESER_ERR_EN)
//
// Build option: define OR16_DESER_ERR_EN to enable framing-error detection,
// where in_first inside a partial word restarts the word and pulses err.

module or16_deser #(
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_a,
    input  logic             in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef OR16_DESER_ERR_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
`ifdef OR16_DESER_ERR_EN
    logic             err_q, err_d;
`endif

    logic accept;
    logic bit_in;

    // Combinational from out_ready so a word can be handed off and the next
    // word's first bit taken on the same edge.
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign bit_in    = in_a | in_b;
    assign out       = out_q;
    assign out_valid = out_valid_q;
`ifdef OR16_DESER_ERR_EN
    assign err       = err_q;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sreg_d      = sreg_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
`ifdef OR16_DESER_ERR_EN
        err_d       = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // Bits without in_first are accepted and dropped.
                if (accept && in_first) begin
                    sreg_d[0] = bit_in;
                    count_d   = CW'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
`ifdef OR16_DESER_ERR_EN
                    if (in_first) begin
                        // Framing error: drop the partial word, restart at bit 0.
                        err_d     = 1'b1;
                        sreg_d    = '0;
                        sreg_d[0] = bit_in;
                        count_d   = CW'(1);
                    end else begin
`else
                    begin
`endif
                        sreg_d[count_q] = bit_in;
                        if (count_q == CW'(WIDTH - 1)) begin
                            out_d       = sreg_d;
                            out_valid_d = 1'b1;
                            count_d     = '0;
                            state_d     = HOLD;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (accept && in_first) begin
                        sreg_d[0] = bit_in;
                        count_d   = CW'(1);
                        state_d   = SHIFT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            sreg_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef OR16_DESER_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sreg_q      <= sreg_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef OR16_DESER_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_or16_deser.sv
// Scoreboard bench for or16_deser: the stimulus side pushes hand-computed
// result words with the cycle they must appear in; a monitor pops and
// compares whenever out_valid rises, and checks the word stays stable while
// it is held.

module tb_or16_deser;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic         in_a;
    logic         in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
`ifdef OR16_DESER_ERR_EN
    logic         err;
    int           err_pulses = 0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] word;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         cur;
    logic         prev_valid = 1'b0;
    logic [W-1:0] held       = '0;

    or16_deser #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef OR16_DESER_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each newly presented word against the scoreboard.
    always @(negedge clk) begin
`ifdef OR16_DESER_ERR_EN
        if (rst_n && err) err_pulses++;
`endif
        if (rst_n && out_valid) begin
            if (!prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%h expected none", out);
                end else begin
                    cur = sb.pop_front();
                    check("word", out, cur.word);
                    check_int("latency_cycle", cyc, cur.cyc);
                end
            end else begin
                check("hold_stable", out, held);
            end
            held = out;
        end
        prev_valid = rst_n && out_valid;
    end

    // Present one bit pair and wait until it is accepted; n = edge index.
    task automatic drive(input logic a, input logic b, input logic first, output int n);
        int   waitc;
        logic acc;
        waitc    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_first = first;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            waitc++;
        end while (!acc && waitc < 200);
        #1;
        n = cyc;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp, input bit stall, output int n);
        for (int i = 0; i < W; i++) begin
            if (stall && i > 0) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drive(a[i], b[i], (i == 0), n);
        end
        sb.push_back('{word: exp, cyc: n});
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n, n1, n2, n3, nbp;
        logic [W-1:0] pa;
        logic [W-1:0] fa;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_a      = 1'b0;
        in_b      = 1'b0;
        out_ready = 1'b1;

        // Reset state
        idle(3);
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        @(negedge clk) rst_n = 1'b1;
        idle(1);
        check("rel_out_valid", W'(out_valid), W'(0));
        check("rel_out", out, 16'h0000);
        check("rel_in_ready", W'(in_ready), W'(1));

        // Single word
        send_word(16'h00F0, 16'h0F01, 16'h0FF1, 1'b0, n);
        idle(3);

        // Back-to-back, no bubbles
        send_word(16'h8000, 16'h0001, 16'h8001, 1'b0, n1);
        send_word(16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, n2);
        send_word(16'h0000, 16'h0000, 16'h0000, 1'b0, n3);
        check_int("b2b_gap1", n2 - n1, 16);
        check_int("b2b_gap2", n3 - n2, 16);
        idle(3);

        // Backpressure for 5 cycles, next first bit waiting upstream
        out_ready = 1'b0;
        send_word(16'h0F0F, 16'h1010, 16'h1F1F, 1'b0, nbp);
        in_valid = 1'b1;
        in_first = 1'b1;
        in_a     = 1'b1;
        in_b     = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", W'(in_ready), W'(0));
            check("bp_out_valid", W'(out_valid), W'(1));
            check("bp_out", out, 16'h1F1F);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_word(16'h0003, 16'h0004, 16'h0007, 1'b0, n);
        check_int("bp_restart_edge", n - nbp, 21);
        idle(3);

        // Random stalls mid-word
        send_word(16'h1234, 16'h4321, 16'h5335, 1'b1, n);
        idle(3);

        // Reset mid-word at count = 7
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, (i == 0), n);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_out", out, 16'h0000);
        check("midrst_in_ready", W'(in_ready), W'(1));
        @(negedge clk) rst_n = 1'b1;
        idle(1);
        check("post_rst_out_valid", W'(out_valid), W'(0));
        send_word(16'h8001, 16'h0100, 16'h8101, 1'b0, n);
        idle(3);

        // Framing: 9-bit partial word, then in_first again with a full word
        pa = 16'h0155;
        fa = 16'h00FF;
        for (int i = 0; i < 9; i++) drive(pa[i], 1'b0, (i == 0), n);
`ifdef OR16_DESER_ERR_EN
        err_pulses = 0;
        for (int i = 0; i < W; i++) drive(fa[i], 1'b0, (i == 0), n);
        sb.push_back('{word: 16'h00FF, cyc: n});
        idle(4);
        check_int("err_pulses", err_pulses, 1);
`else
        for (int i = 0; i < W; i++) begin
            drive(fa[i], 1'b0, (i == 0), n);
            if (i == 6) sb.push_back('{word: 16'hFF55, cyc: n});
        end
        idle(4);
`endif

        idle(5);
        check_int("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
